pipe_skid_buffer: RTL



---
 rtl/pipe_skid_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipe_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buffer
// Description : Two-entry registered pipeline stage with valid/ready
//               handshake on both sides. The head word lives in the main
//               register and drives out_data. A second word is parked in the
//               skid register when downstream stalls. in_ready comes straight
//               from a flop, so the upstream ready path has no combinational
//               dependency on out_ready.
// Ports       :
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous discard of all held words (beats push and pop)
//   in_valid   upstream word present on in_data
//   in_ready   buffer can accept a word this cycle (registered)
//   in_data    upstream word
//   out_valid  out_data holds a valid word
//   out_ready  downstream takes out_data this cycle
//   out_data   head word (main register)
//   count      number of held words: 0, 1 or 2
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  // The encoding equals the number of held words, so count decodes directly.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] main_reg;
  logic [WIDTH-1:0] main_next;
  logic [WIDTH-1:0] skid_reg;
  logic [WIDTH-1:0] skid_next;
  logic             in_ready_reg;
  logic             push;
  logic             pop;

  // --------------------------------------------------------------------------
  // State and storage registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state        <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      // Ready for the coming cycle is decided from the next state, keeping
      // the upstream ready a pure flop output.
      in_ready_reg <= (state_next != S_FULL);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-storage logic
  // --------------------------------------------------------------------------
  always_comb begin
    push       = in_valid & in_ready_reg;
    pop        = out_ready & (state != S_EMPTY);
    state_next = state;
    main_next  = main_reg;
    skid_next  = skid_reg;

    if (flush) begin
      state_next = S_EMPTY;
      main_next  = '0;
      skid_next  = '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (push) begin
            main_next  = in_data;
            state_next = S_BUSY;
          end
        end
        S_BUSY: begin
          if (push && pop) begin
            // Head leaves and the new word replaces it in the same edge.
            main_next = in_data;
          end else if (push) begin
            skid_next  = in_data;
            state_next = S_FULL;
          end else if (pop) begin
            // main keeps its stale value; it is hidden by out_valid = 0.
            state_next = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so no push can occur.
          if (pop) begin
            main_next  = skid_reg;
            state_next = S_BUSY;
          end
        end
        default: begin
          state_next = S_EMPTY;
          main_next  = '0;
          skid_next  = '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    count     = 2'd0;
    case (state)
      S_BUSY: begin
        out_valid = 1'b1;
        count     = 2'd1;
      end
      S_FULL: begin
        out_valid = 1'b1;
        count     = 2'd2;
      end
      default: begin
        out_valid = 1'b0;
        count     = 2'd0;
      end
    endcase
  end

  assign in_ready = in_ready_reg;
  assign out_data = main_reg;

endmodule
`default_nettype wire
